// File: rtl/mdio_pkg.sv
// Clause-22 MDIO frame layout, opcodes and slave FSM encoding shared by the
// management generator and the PHY-side peripheral.
package mdio_pkg;

  localparam int FRAME_BITS = 32;

  // Bit positions within the 32-bit frame, MSB transmitted first
  localparam int ST_HI    = 31;
  localparam int ST_LO    = 30;
  localparam int OP_HI    = 29;
  localparam int OP_LO    = 28;
  localparam int PHYAD_HI = 27;
  localparam int PHYAD_LO = 23;
  localparam int REGAD_HI = 22;
  localparam int REGAD_LO = 18;
  localparam int TA_HI    = 17;
  localparam int TA_LO    = 16;
  localparam int DATA_HI  = 15;
  localparam int DATA_LO  = 0;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] TA_WR    = 2'b10;

  localparam logic [4:0] HDR_LAST  = 5'(OP_HI - REGAD_LO);
  localparam logic [4:0] DATA_LAST = 5'(DATA_HI - DATA_LO);
  localparam logic [4:0] CNT_SAT   = 5'd16;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] phyad;
    logic [4:0] regad;
  } hdr_t;

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_HEADER  = 7'b0000010,
    S_TA_WR   = 7'b0000100,
    S_WR_DATA = 7'b0001000,
    S_TA_RD   = 7'b0010000,
    S_RD_DATA = 7'b0100000,
    S_IGNORE  = 7'b1000000
  } state_t;

  function automatic logic [4:0] cnt_inc(input logic [4:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + 5'd1;
  endfunction

  function automatic logic op_ok(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdio_edge_det.sv
// MDC edge detector: one-clk rise/fall pulses, combinational off a single mdc_q flop.
// Latency: pulse lasts the clk cycle in which mdc differs from mdc_q; no backpressure.
module mdio_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_q;

  always_ff @(posedge clk) begin
    if (reset) mdc_q <= 1'b0;
    else       mdc_q <= mdc;
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side clause-22 MDIO slave: frames in, one-clk wr/rd strobes to a register file, read data out.
// Latency: strobes 1 clk after the deciding MDC rise; no backpressure, the MDC master paces everything.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic        mdio_in_oe,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_stb,
  input  logic [15:0] rd_data,
  output logic        frame_err
);

  logic        rise;
  logic        fall;
  state_t      state;
  logic [4:0]  bit_cnt;
  logic [1:0]  hist;
  logic        hist_vld;
  hdr_t        hdr_sh;
  hdr_t        hdr_nxt;
  logic [15:0] rx_sh;
  logic [15:0] tx_sh;
  logic        wr_pend;
  logic        rd_pend;
  logic        tx_ld;
  logic        ign_ph;
  logic        ta_exp;

  mdio_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .mdc   (mdc),
    .rise  (rise),
    .fall  (fall)
  );

  assign hdr_nxt = {hdr_sh[10:0], mdio_out};
  assign ta_exp  = bit_cnt[0] ? TA_WR[0] : TA_WR[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      hist       <= '0;
      hist_vld   <= 1'b0;
      hdr_sh     <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      wr_pend    <= 1'b0;
      rd_pend    <= 1'b0;
      tx_ld      <= 1'b0;
      ign_ph     <= 1'b0;
      mdio_in    <= 1'b0;
      mdio_in_oe <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      frame_err <= 1'b0;

      // Register file answers one clk after rd_stb; capture it the clk after that.
      tx_ld <= rd_stb;
      if (tx_ld) tx_sh <= rd_data;

      if (wr_pend) begin
        wr_pend <= 1'b0;
        wr_stb  <= 1'b1;
        wr_data <= rx_sh;
        addr    <= hdr_sh.regad;
      end
      if (rd_pend) begin
        rd_pend <= 1'b0;
        rd_stb  <= 1'b1;
        addr    <= hdr_sh.regad;
      end

      // ST history only counts samples taken while sitting in IDLE
      if (state != S_IDLE) hist_vld <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rise) begin
            if (mdio_oe) begin
              hist     <= {hist[0], mdio_out};
              hist_vld <= 1'b1;
              if (hist_vld && ({hist[0], mdio_out} == ST_CODE)) begin
                state    <= S_HEADER;
                bit_cnt  <= '0;
                hist_vld <= 1'b0;
              end
            end else begin
              hist_vld <= 1'b0;
            end
          end
        end

        S_HEADER: begin
          if (rise) begin
            if (!mdio_oe) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
              bit_cnt   <= '0;
            end else begin
              hdr_sh  <= hdr_nxt;
              bit_cnt <= cnt_inc(bit_cnt);
              if (bit_cnt == HDR_LAST) begin
                bit_cnt <= '0;
                if ((hdr_nxt.phyad != PHY_ADDR) || !op_ok(hdr_nxt.op)) begin
                  state  <= S_IGNORE;
                  ign_ph <= 1'b0;
                end else if (hdr_nxt.op == OP_WRITE) begin
                  state <= S_TA_WR;
                end else begin
                  state   <= S_TA_RD;
                  rd_pend <= 1'b1;
                end
              end
            end
          end
        end

        S_TA_WR: begin
          if (rise) begin
            if (!mdio_oe || (mdio_out != ta_exp)) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
              bit_cnt   <= '0;
            end else if (bit_cnt == 5'd1) begin
              state   <= S_WR_DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= cnt_inc(bit_cnt);
            end
          end
        end

        S_WR_DATA: begin
          if (rise) begin
            if (!mdio_oe) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
              bit_cnt   <= '0;
            end else begin
              rx_sh <= {rx_sh[14:0], mdio_out};
              if (bit_cnt == DATA_LAST) begin
                wr_pend <= 1'b1;
                state   <= S_IDLE;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= cnt_inc(bit_cnt);
              end
            end
          end
        end

        S_TA_RD: begin
          // Float during the first TA bit, drive the 0 of the second from the fall after it
          if (rise) begin
            bit_cnt <= cnt_inc(bit_cnt);
          end else if (fall && (bit_cnt == 5'd1)) begin
            mdio_in_oe <= 1'b1;
            mdio_in    <= 1'b0;
            state      <= S_RD_DATA;
            bit_cnt    <= '0;
          end
        end

        S_RD_DATA: begin
          if (fall) begin
            if (bit_cnt == CNT_SAT) begin
              mdio_in_oe <= 1'b0;
              mdio_in    <= 1'b0;
              state      <= S_IDLE;
              bit_cnt    <= '0;
            end else begin
              mdio_in <= tx_sh[15];
              tx_sh   <= {tx_sh[14:0], 1'b0};
              bit_cnt <= cnt_inc(bit_cnt);
            end
          end
        end

        S_IGNORE: begin
          // Two TA bits, then 16 data bits; the counter saturates at 16 so phase is split
          if (rise) begin
            if (!ign_ph && (bit_cnt == 5'd1)) begin
              ign_ph  <= 1'b1;
              bit_cnt <= '0;
            end else if (ign_ph && (bit_cnt == DATA_LAST)) begin
              state   <= S_IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= cnt_inc(bit_cnt);
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
